// File: rtl/core_pipe_pkg.sv
// Shared payload layouts for the 5-stage core's inter-stage registers.
// Control fields sit in the LSBs of each payload so the bubble mask zeroes exactly them.
package core_pipe_pkg;

  typedef struct packed {
    logic pred_taken;
    logic instr_valid;
  } if_id_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    if_id_ctrl_t ctrl;
  } if_id_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       reg_write;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    id_ex_ctrl_t ctrl;
  } id_ex_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0]  alu_res;
    logic [31:0]  store_val;
    logic [4:0]   rd;
    ex_mem_ctrl_t ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } mem_wb_ctrl_t;

  typedef struct packed {
    logic [31:0]  alu_res;
    logic [31:0]  load_val;
    logic [4:0]   rd;
    mem_wb_ctrl_t ctrl;
  } mem_wb_t;

  localparam int IF_ID_W       = $bits(if_id_t);
  localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
  localparam int ID_EX_W       = $bits(id_ex_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_W      = $bits(ex_mem_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_W      = $bits(mem_wb_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data storage entry; clear wins over load for the valid bit.
module pipe_skid_entry #(
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
    if (clear_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional skid entry,
// bubble masking of the control field and a saturating back-pressure counter.
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              in_fire, out_fire;
  logic              main_v, main_load, main_clr;
  logic [DATA_W-1:0] main_d, main_wdata;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = main_v & out_ready_i;

  pipe_skid_entry #(.DATA_W(DATA_W)) u_main (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (main_load),
    .clear_i (main_clr),
    .data_i  (main_wdata),
    .valid_o (main_v),
    .data_o  (main_d)
  );

  if (SKID != 0) begin : g_skid
    logic              skid_v, skid_load, skid_clr;
    logic [DATA_W-1:0] skid_d;

    // Ready depends only on the skid flop, so upstream never sees out_ready_i combinationally.
    assign in_ready_o = ~skid_v;
    assign main_load  = (out_fire & skid_v) | (in_fire & (~main_v | out_fire));
    assign main_wdata = skid_v ? skid_d : in_data_i;
    assign main_clr   = flush_i | (out_fire & ~main_load);
    assign skid_load  = in_fire & main_v & ~out_fire;
    assign skid_clr   = flush_i | (out_fire & skid_v);

    pipe_skid_entry #(.DATA_W(DATA_W)) u_skid (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .data_i  (in_data_i),
      .valid_o (skid_v),
      .data_o  (skid_d)
    );
  end else begin : g_noskid
    assign in_ready_o = ~main_v | out_ready_i;
    assign main_load  = in_fire;
    assign main_wdata = in_data_i;
    assign main_clr   = flush_i | (out_fire & ~in_fire);
  end

  assign out_valid_o = main_v;

  always_comb begin
    out_data_o = main_d;
    if (!main_v) begin
      for (int i = 0; i < CTRL_W; i++) out_data_o[i] = 1'b0;
    end
  end

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr_i)                stall_cnt_d = '0;
    else if (main_v && !out_ready_i)    stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=0 and a SKID=1 instance with the same stimulus and checks both
// against a queue-occupancy reference model every cycle.
module tb_pipe_stage_reg;
  localparam int DW   = 16;
  localparam int CW   = 8;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, in_valid, out_ready, clr;
  logic [DW-1:0] in_data;
  logic [1:0]    ov, ir;
  logic [DW-1:0] od [2];
  logic [CNTW-1:0] sc [2];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(CNTW)) u_noskid (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(ir[0]), .in_data_i(in_data), .out_valid_o(ov[0]),
    .out_ready_i(out_ready), .out_data_o(od[0]), .stall_cnt_clr_i(clr),
    .stall_cnt_o(sc[0]));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(CNTW)) u_skid (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(ir[1]), .in_data_i(in_data), .out_valid_o(ov[1]),
    .out_ready_i(out_ready), .out_data_o(od[1]), .stall_cnt_clr_i(clr),
    .stall_cnt_o(sc[1]));

  // Reference model: FIFO contents (capacity 1 or 2), stall count, "data known zero" flag.
  logic [DW-1:0] mq [2][2];
  int  mn   [2];
  int  mcnt [2];
  bit  dz   [2];
  bit  armed = 1'b0;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s skid=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input int k);
    if (k == 1) return mn[1] < 2;
    return (mn[0] == 0) || out_ready;
  endfunction

  task automatic step(input bit r, input bit fl, input bit iv, input logic [DW-1:0] d,
                      input bit ordy, input bit cl);
    bit in_f, out_f;
    @(negedge clk);
    rst_n = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy; clr = cl;
    #1;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk("out_valid", k, 32'(ov[k]), 32'(mn[k] > 0));
        chk("in_ready",  k, 32'(ir[k]), 32'(exp_ready(k)));
        chk("stall_cnt", k, 32'(sc[k]), mcnt[k]);
        if (mn[k] > 0)  chk("out_data", k, 32'(od[k]), 32'(mq[k][0]));
        else if (dz[k]) chk("out_data_rst", k, 32'(od[k]), 32'd0);
        else            chk("ctrl_mask", k, 32'(od[k][CW-1:0]), 32'd0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      in_f  = iv && exp_ready(k);
      out_f = (mn[k] > 0) && ordy;
      if (!r) begin
        mn[k] = 0; mcnt[k] = 0; dz[k] = 1'b1;
      end else begin
        if (cl) mcnt[k] = 0;
        else if (mn[k] > 0 && !ordy && mcnt[k] < (1 << CNTW) - 1) mcnt[k]++;
        if (out_f) begin mq[k][0] = mq[k][1]; mn[k]--; end
        if (in_f)  begin mq[k][mn[k]] = d; mn[k]++; dz[k] = 1'b0; end
        if (fl) mn[k] = 0;
      end
    end
    if (!r) armed = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr = 1'b0;
    for (int k = 0; k < 2; k++) begin mn[k] = 0; mcnt[k] = 0; dz[k] = 1'b1; end

    // Reset for two cycles, then idle
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, 32'(ir[k]), 32'd1);
      chk("rst_data",  k, 32'(od[k]), 32'd0);
    end

    // Streaming with out_ready held high
    step(1'b1, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0033, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) chk("stream_last", k, 32'(od[k]), 32'h33);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Back-pressure: A1, A2 captured, A3 held, then release
    step(1'b1, 1'b0, 1'b1, 16'h50A1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h50A2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h50A3, 1'b0, 1'b0);
    chk("bp_ready", 1, 32'(ir[1]), 32'd0);
    step(1'b1, 1'b0, 1'b1, 16'h50A3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h50A3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h50A3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Flush with skid full while B3 is offered
    step(1'b1, 1'b0, 1'b1, 16'h60B1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h60B2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h60B3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("flush_valid", 1, 32'(ov[1]), 32'd0);
    chk("flush_ready", 1, 32'(ir[1]), 32'd1);
    chk("flush_mask",  1, 32'(od[1][CW-1:0]), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Reset while full and stalled, then reset together with flush
    step(1'b1, 1'b0, 1'b1, 16'h70C1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h70C2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h70C3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h70D1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h70D2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h70D3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) chk("rst_flush_cnt", k, 32'(sc[k]), 32'd0);

    // Counter saturation and clear during a stall
    step(1'b1, 1'b0, 1'b1, 16'h80E1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) chk("cnt_sat", k, 32'(sc[k]), 32'd15);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) chk("cnt_clr", k, 32'(sc[k]), 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) chk("cnt_resume", k, 32'(sc[k]), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) != 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
           DW'($urandom), $urandom_range(9) < 6, $urandom_range(29) == 0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
